// File: rtl/clk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_pkg : shared divide codes, FSM encoding and divide-limit helper   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clk_pkg;

  localparam logic [1:0] DIV1 = 2'd0;
  localparam logic [1:0] DIV2 = 2'd1;
  localparam logic [1:0] DIV4 = 2'd2;
  localparam logic [1:0] DIV8 = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

  // Last period-counter value for a divide code: (1<<code)-1.
  function automatic logic [2:0] div_max(input logic [1:0] code);
    logic [3:0] w_full;
    w_full = (4'd1 << code) - 4'd1;
    return w_full[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_lock_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_lock_filter : requires LOCK_CYCLES consecutive locked cycles      |
// | while enabled before declaring the clock stable.  Rev 1.0            |
// +----------------------------------------------------------------------+
module clk_lock_filter #(
  parameter int LOCK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic enable,
  output logic stable
);

  localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0] c_scnt_last = SW'(LOCK_CYCLES - 1);

  logic [SW-1:0] r_scnt;

  assign stable = enable && pll_locked && (r_scnt == c_scnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt <= '0;
    end else if (!enable || !pll_locked) begin
      r_scnt <= '0;
    end else if (!stable) begin
      r_scnt <= r_scnt + SW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_en_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_en_ctrl : lock-gated clock-enable generator (/1,/2,/4,/8) with    |
// | boundary-aligned rate changes via req/ack and a guard interval. R1.0 |
// +----------------------------------------------------------------------+
module clk_en_ctrl
  import clk_pkg::*;
#(
  parameter int         LOCK_CYCLES  = 4,
  parameter int         GUARD_CYCLES = 2,
  parameter logic [1:0] RESET_DIV    = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       run,
  input  logic       cfg_req,
  input  logic [1:0] cfg_div,
  output logic       cfg_ack,
  output logic       ce,
  output logic       ready,
  output logic [1:0] cur_div
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] c_gcnt_last = GW'(GUARD_CYCLES - 1);

  state_t        r_state, w_state_n;
  logic [2:0]    r_cnt, w_cnt_n;
  logic [GW-1:0] r_gcnt, w_gcnt_n;
  logic          r_ce, w_ce_n;
  logic          r_ack, w_ack_n;
  logic          r_ready, w_ready_n;
  logic [1:0]    r_cur_div, w_div_n;

  logic          w_stable;
  logic          w_at_max;

  clk_lock_filter #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_filter (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .enable     (r_state == ST_SETTLE),
    .stable     (w_stable)
  );

  assign w_at_max = (r_cnt == div_max(r_cur_div));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_WAIT_LOCK;
      r_cnt     <= '0;
      r_gcnt    <= '0;
      r_ce      <= 1'b0;
      r_ack     <= 1'b0;
      r_ready   <= 1'b0;
      r_cur_div <= RESET_DIV;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_gcnt    <= w_gcnt_n;
      r_ce      <= w_ce_n;
      r_ack     <= w_ack_n;
      r_ready   <= w_ready_n;
      r_cur_div <= w_div_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_gcnt_n  = r_gcnt;
    w_ce_n    = 1'b0;
    w_ack_n   = 1'b0;
    w_ready_n = r_ready;
    w_div_n   = r_cur_div;

    // Lock loss wins over everything; cur_div and any pending request survive.
    if (!pll_locked) begin
      w_state_n = ST_WAIT_LOCK;
      w_cnt_n   = '0;
      w_gcnt_n  = '0;
      w_ready_n = 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          w_state_n = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_stable) begin
            w_state_n = ST_RUN;
            w_ready_n = 1'b1;
            w_cnt_n   = '0;
          end
        end
        ST_RUN: begin
          if (cfg_req && (!run || w_at_max)) begin
            w_div_n   = cfg_div;
            w_cnt_n   = '0;
            w_ack_n   = 1'b1;
            w_gcnt_n  = '0;
            w_ce_n    = run;
            w_state_n = ST_HOLD;
          end else if (run && w_at_max) begin
            w_ce_n  = 1'b1;
            w_cnt_n = '0;
          end else if (run) begin
            w_cnt_n = r_cnt + 3'd1;
          end
        end
        ST_HOLD: begin
          if (r_gcnt == c_gcnt_last) begin
            w_state_n = ST_RUN;
            w_cnt_n   = '0;
          end else begin
            w_gcnt_n = r_gcnt + GW'(1);
          end
        end
        default: begin
          w_state_n = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign cfg_ack = r_ack;
  assign ce      = r_ce;
  assign ready   = r_ready;
  assign cur_div = r_cur_div;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clk_en_ctrl : directed self-checking bench for clk_en_ctrl         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_clk_en_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       run;
  logic       cfg_req;
  logic [1:0] cfg_div;
  logic       cfg_ack;
  logic       ce;
  logic       ready;
  logic [1:0] cur_div;

  int n_total = 0;
  int n_bad   = 0;
  int n;

  clk_en_ctrl #(
    .LOCK_CYCLES  (4),
    .GUARD_CYCLES (2),
    .RESET_DIV    (2'd0)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .run        (run),
    .cfg_req    (cfg_req),
    .cfg_div    (cfg_div),
    .cfg_ack    (cfg_ack),
    .ce         (ce),
    .ready      (ready),
    .cur_div    (cur_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_total++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks_to_ce(input int max_t, output int cnt_o);
    cnt_o = -1;
    for (int i = 1; i <= max_t; i++) begin
      tick();
      if (ce) begin
        cnt_o = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pll_locked = 1'b0; run = 1'b0; cfg_req = 1'b0; cfg_div = 2'd0;
    repeat (2) tick();
    chk("rst_ce", ce, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_div", cur_div, 0);
    rst = 1'b0;
    tick();
    chk("unlocked_ready", ready, 0);

    // Lock: edge 0 samples lock, ready after edge 4
    pll_locked = 1'b1;
    tick();
    chk("lock_e0_ready", ready, 0);
    repeat (3) tick();
    chk("lock_e3_ready", ready, 0);
    chk("lock_e3_ce", ce, 0);
    tick();
    chk("lock_e4_ready", ready, 1);
    chk("lock_div", cur_div, 0);

    // Idle change to /4
    cfg_req = 1'b1; cfg_div = 2'd2;
    tick();
    chk("idle4_ack", cfg_ack, 1);
    chk("idle4_ce", ce, 0);
    chk("idle4_div", cur_div, 2);
    cfg_req = 1'b0;
    tick();
    chk("idle4_ack_pulse", cfg_ack, 0);
    tick();
    run = 1'b1;
    ticks_to_ce(12, n);
    chk("div4_first", n, 4);
    ticks_to_ce(12, n);
    chk("div4_period", n, 4);
    tick();
    chk("div4_mid_ce", ce, 0);
    run = 1'b0;
    repeat (3) tick();
    chk("div4_frozen_ce", ce, 0);
    run = 1'b1;
    ticks_to_ce(12, n);
    chk("div4_stretch", n, 3);

    // Idle change to /8: ack, no ce
    run = 1'b0; cfg_req = 1'b1; cfg_div = 2'd3;
    tick();
    chk("idle8_ack", cfg_ack, 1);
    chk("idle8_ce", ce, 0);
    chk("idle8_div", cur_div, 3);
    cfg_req = 1'b0;
    repeat (2) tick();
    run = 1'b1;
    repeat (3) tick();
    // cnt is now 3: request /2
    cfg_req = 1'b1; cfg_div = 2'd1;
    repeat (4) tick();
    chk("chg_wait_ack", cfg_ack, 0);
    chk("chg_wait_ce", ce, 0);
    tick();
    chk("chg_ack", cfg_ack, 1);
    chk("chg_last_ce", ce, 1);
    chk("chg_div", cur_div, 1);
    cfg_req = 1'b0;
    ticks_to_ce(12, n);
    chk("chg_first_new", n, 4);
    ticks_to_ce(12, n);
    chk("div2_period", n, 2);

    // Lock loss mid-HOLD with a second request pending
    cfg_req = 1'b1; cfg_div = 2'd2;
    tick();
    tick();
    chk("ll_apply_ack", cfg_ack, 1);
    chk("ll_apply_ce", ce, 1);
    cfg_div = 2'd3;
    pll_locked = 1'b0;
    tick();
    chk("ll_ce", ce, 0);
    chk("ll_ready", ready, 0);
    chk("ll_ack", cfg_ack, 0);
    chk("ll_div_kept", cur_div, 2);
    tick();
    chk("ll_wait_ack", cfg_ack, 0);
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("relock_e3_ready", ready, 0);
    tick();
    chk("relock_ready", ready, 1);
    chk("relock_ack", cfg_ack, 0);
    repeat (3) tick();
    chk("relock_pre_ack", cfg_ack, 0);
    tick();
    chk("relock_ack_bnd", cfg_ack, 1);
    chk("relock_ce_bnd", ce, 1);
    chk("relock_div", cur_div, 3);
    cfg_req = 1'b0;

    // /1 continuous, then async reset
    repeat (2) tick();
    run = 1'b0; cfg_req = 1'b1; cfg_div = 2'd0;
    tick();
    chk("idle1_ack", cfg_ack, 1);
    chk("idle1_div", cur_div, 0);
    cfg_req = 1'b0; run = 1'b1;
    repeat (2) tick();
    chk("div1_guard_ce", ce, 0);
    tick();
    chk("div1_ce0", ce, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("div1_ce", ce, 1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ce", ce, 0);
    chk("arst_ready", ready, 0);
    chk("arst_div", cur_div, 0);
    #10;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
